// File: rtl/rx_com_aligner.sv
// rtl/rx_com_aligner.sv - serial-to-byte recovery aligned on COM; optional loss-of-lock under RX_LOCK_LOSS_EN
module rx_com_aligner #(
   parameter logic [7:0] COM_CHAR   = 8'hBC,
   parameter int         LOCK_COUNT = 4,
   parameter int         MAX_GAP    = 16
) (
   input  logic       dclk,
   input  logic       default_values,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

   state_t     state_q, state_d;
   // Only the newest 7 bits are kept; together with data_in they form the
   // 8-bit window, so the oldest bit of the byte-wide shifter is never needed.
   logic [6:0] shift_reg;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] com_cnt_q, com_cnt_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic [7:0] word;
   logic       is_com;
   logic       word_edge;

`ifdef RX_LOCK_LOSS_EN
   localparam logic [7:0] GAP_TGT = 8'(MAX_GAP);
   logic [7:0] gap_q, gap_d;
`endif

   // Word is judged at the same edge that shifts in its last bit.
   assign word      = {shift_reg, data_in};
   assign is_com    = (word == COM_CHAR);
   assign word_edge = (bit_cnt_q == 3'd7);

   // Next-state and next-output decisions for the alignment FSM.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
`ifdef RX_LOCK_LOSS_EN
      gap_d     = gap_q;
`endif
      case (state_q)
         SEARCH: begin
            // Sliding compare on every bit until a COM shows up.
            bit_cnt_d = 3'd0;
            if (is_com) begin
               state_d   = ALIGN;
               com_cnt_d = 4'd1;
            end
         end
         ALIGN: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (word_edge) begin
               if (is_com) begin
                  com_cnt_d = com_cnt_q + 4'd1;
                  if (com_cnt_q + 4'd1 == LOCK_TGT) begin
                     state_d = LOCKED;
                  end
               end else begin
                  // Phase guess was wrong; resume bitwise search next edge.
                  state_d   = SEARCH;
                  com_cnt_d = 4'd0;
                  bit_cnt_d = 3'd0;
               end
            end
         end
         LOCKED: begin
            // Phase is frozen here; off-phase COMs are never looked at.
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (word_edge) begin
               if (!is_com) begin
`ifdef RX_LOCK_LOSS_EN
                  if (gap_q + 8'd1 == GAP_TGT) begin
                     // Too long without fill: drop this word and re-acquire.
                     state_d   = SEARCH;
                     com_cnt_d = 4'd0;
                     bit_cnt_d = 3'd0;
                     gap_d     = 8'd0;
                  end else begin
                     gap_d   = gap_q + 8'd1;
                     data_d  = word;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = word;
                  valid_d = 1'b1;
`endif
               end
`ifdef RX_LOCK_LOSS_EN
               else begin
                  gap_d = 8'd0;
               end
`endif
            end
         end
         default: begin
            state_d   = SEARCH;
            bit_cnt_d = 3'd0;
            com_cnt_d = 4'd0;
         end
      endcase
   end

   // State, shifter and output registers; reset discards any partial word.
   always_ff @(posedge dclk or posedge default_values) begin
      if (default_values) begin
         state_q   <= SEARCH;
         shift_reg <= 7'd0;
         bit_cnt_q <= 3'd0;
         com_cnt_q <= 4'd0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_reg <= word[6:0];
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

`ifdef RX_LOCK_LOSS_EN
   // Count of consecutive non-COM words seen while locked.
   always_ff @(posedge dclk or posedge default_values) begin
      if (default_values) begin
         gap_q <= 8'd0;
      end else begin
         gap_q <= gap_d;
      end
   end
`endif

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_com_aligner.sv
// tb/tb_rx_com_aligner.sv - directed bench for rx_com_aligner (honours RX_LOCK_LOSS_EN)
module tb_rx_com_aligner;

   logic       dclk;
   logic       default_values;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int         tests     = 0;
   int         fails     = 0;
   int         ticks     = 0;
   int         strobes   = 0;
   int         last_tick = 0;
   int         t_ref     = 0;
   int         s_ref     = 0;
   logic [7:0] last_data = 8'h00;

   rx_com_aligner dut (
      .dclk           (dclk),
      .default_values (default_values),
      .data_in        (data_in),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .active         (active)
   );

   initial begin
      dclk = 1'b0;
      forever #5 dclk = ~dclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one bit, let one edge pass, sample outputs 1 time unit later.
   task automatic send_bit(input logic b);
      data_in = b;
      @(posedge dclk);
      #1;
      ticks++;
      if (valid_out === 1'b1) begin
         strobes++;
         last_tick = ticks;
         last_data = data_out;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic send_coms(input int n);
      for (int k = 0; k < n; k++) send_byte(8'hBC);
   endtask

   task automatic do_reset;
      #2 default_values = 1'b1;
      #2 default_values = 1'b0;
   endtask

   initial begin
      default_values = 1'b0;
      data_in        = 1'b0;
      @(posedge dclk);
      #1;
      do_reset;
      check("rst_data", 32'(data_out), 32'h00);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_active", 32'(active), 32'd0);

      // 1: junk bits then four COMs
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_coms(3);
      check("t1_active_after3", 32'(active), 32'd0);
      send_byte(8'hBC);
      check("t1_active_after4", 32'(active), 32'd1);
      check("t1_no_strobe", 32'(strobes), 32'd0);

      // 2: payload, COM fill, payload
      send_byte(8'hA5);
      check("t2_a5_valid", 32'(valid_out), 32'd1);
      check("t2_a5_data", 32'(data_out), 32'hA5);
      check("t2_a5_strobes", 32'(strobes), 32'd1);
      t_ref = last_tick;
      send_byte(8'hBC);
      check("t2_com_valid", 32'(valid_out), 32'd0);
      check("t2_com_hold", 32'(data_out), 32'hA5);
      check("t2_com_strobes", 32'(strobes), 32'd1);
      send_byte(8'h3C);
      check("t2_3c_valid", 32'(valid_out), 32'd1);
      check("t2_3c_data", 32'(last_data), 32'h3C);
      check("t2_3c_strobes", 32'(strobes), 32'd2);
      check("t2_spacing", 32'(last_tick - t_ref), 32'd16);

      // 4: asynchronous reset mid-byte while locked
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      #2 default_values = 1'b1;
      #1;
      check("t4_data", 32'(data_out), 32'h00);
      check("t4_valid", 32'(valid_out), 32'd0);
      check("t4_active", 32'(active), 32'd0);
      #2 default_values = 1'b0;
      s_ref = strobes;
      send_coms(3);
      check("t4_active_after3", 32'(active), 32'd0);
      send_byte(8'hBC);
      check("t4_active_after4", 32'(active), 32'd1);
      check("t4_no_strobe", 32'(strobes), 32'(s_ref));

      // 3: alignment broken by a non-COM before lock
      do_reset;
      send_coms(2);
      check("t3_active_align", 32'(active), 32'd0);
      send_byte(8'h55);
      check("t3_active_55", 32'(active), 32'd0);
      check("t3_valid_55", 32'(valid_out), 32'd0);
      send_coms(3);
      check("t3_active_after3", 32'(active), 32'd0);
      send_byte(8'hBC);
      check("t3_active_after4", 32'(active), 32'd1);
      check("t3_no_strobe", 32'(strobes), 32'(s_ref));

      // 6: 1-bit offset, 0x5E decoy, then true-phase COMs and payload
      do_reset;
      send_bit(1'b0);
      send_byte(8'h5E);
      send_coms(3);
      check("t6_active_after3", 32'(active), 32'd0);
      send_byte(8'hBC);
      check("t6_active_after4", 32'(active), 32'd1);
      send_byte(8'hC3);
      check("t6_c3_valid", 32'(valid_out), 32'd1);
      check("t6_c3_data", 32'(data_out), 32'hC3);
      check("t6_strobes", 32'(strobes), 32'(s_ref + 1));

      // 5: sixteen consecutive non-COM words after lock
      do_reset;
      send_coms(4);
      check("t5_locked", 32'(active), 32'd1);
      s_ref = strobes;
      for (int n = 0; n < 16; n++) send_byte(8'h11);
`ifdef RX_LOCK_LOSS_EN
      check("t5_strobes", 32'(strobes - s_ref), 32'd15);
      check("t5_active", 32'(active), 32'd0);
      check("t5_valid_last", 32'(valid_out), 32'd0);
`else
      check("t5_strobes", 32'(strobes - s_ref), 32'd16);
      check("t5_active", 32'(active), 32'd1);
      check("t5_valid_last", 32'(valid_out), 32'd1);
`endif
      check("t5_data", 32'(data_out), 32'h11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
